// File: rtl/par8_cmd_controller_if.sv
// ============================================================================
// Module      : par8_cmd_controller_if
// Description : Bundles the receiver, transmitter and MD5-core signals seen
//               by par8_cmd_controller.
//               master : the command controller itself
//               slave  : receiver/transmitter/core side (or a testbench)
// Ports       : rxd_data/rxd_data_ready  receiver byte + strobe
//               desync                   pulse back to the receiver
//               txd_data/tx_valid        byte + strobe to the transmitter
//               tx_ready_next            transmitter can take a byte
//               dn_data/dn_valid         payload byte + strobe to the core
//               result_data/result_valid/core_busy  core status and result
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface par8_cmd_controller_if #(
    parameter int RESULT_BYTES = 4
);
    logic [7:0]                rxd_data;
    logic                      rxd_data_ready;
    logic                      desync;
    logic [7:0]                txd_data;
    logic                      tx_valid;
    logic                      tx_ready_next;
    logic [7:0]                dn_data;
    logic                      dn_valid;
    logic [8*RESULT_BYTES-1:0] result_data;
    logic                      result_valid;
    logic                      core_busy;

    modport master (
        input  rxd_data, rxd_data_ready, tx_ready_next,
               result_data, result_valid, core_busy,
        output desync, txd_data, tx_valid, dn_data, dn_valid
    );

    modport slave (
        output rxd_data, rxd_data_ready, tx_ready_next,
               result_data, result_valid, core_busy,
        input  desync, txd_data, tx_valid, dn_data, dn_valid
    );
endinterface

`default_nettype wire

// File: rtl/par8_cmd_controller.sv
// ============================================================================
// Module      : par8_cmd_controller
// Description : Command sequencer between the par8 receiver/transmitter and
//               the MD5 core. Decodes host opcodes (TEST 01, LOAD 02,
//               STATUS 03, DESYNC 05, anything else NAK), forwards LOAD
//               payload to the core and queues response bytes.
// Ports       : clk    system clock
//               reset  synchronous, active-low
//               bus    par8_cmd_controller_if.master (see interface header)
// Config      : define CMD_TIMEOUT_EN to abort partial commands after
//               TIMEOUT_CYCLES idle cycles (desync pulse, timeout flag set).
//               Without it partial commands wait forever and the timeout
//               status bit reads 0.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module par8_cmd_controller #(
    parameter int         RESULT_BYTES = 4,
    parameter logic [7:0] ACK_BYTE     = 8'h01,
    parameter logic [7:0] NAK_BYTE     = 8'hEE
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    par8_cmd_controller_if.master  bus
);

    localparam int IDX_W = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESULT_BYTES - 1);

    localparam logic [7:0] OP_TEST   = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;
    localparam logic [7:0] OP_DESYNC = 8'h05;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TEST_ARG  = 4'd1,
        ST_LOAD_LEN  = 4'd2,
        ST_LOAD_DATA = 4'd3,
        ST_TX_STATUS = 4'd4,
        ST_TX_RESULT = 4'd5,
        ST_TX_ACK    = 4'd6,
        ST_TX_NAK    = 4'd7,
        ST_TX_ECHO   = 4'd8,
        ST_DESYNC    = 4'd9
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [7:0]                r_arg, w_arg_nxt;
    logic [7:0]                r_count, w_count_nxt;
    logic [IDX_W-1:0]          r_idx, w_idx_nxt;
    logic [8*RESULT_BYTES-1:0] r_result, w_result_nxt;
    logic [7:0]                r_status, w_status_nxt;
    logic                      r_overrun, w_overrun_nxt;
    logic                      r_ovr_resp, w_ovr_resp_nxt;
    logic                      r_timeout, w_timeout_nxt;
    logic [7:0]                r_txd_data, w_txd_data_nxt;
    logic                      r_tx_valid, w_tx_valid_nxt;
    logic [7:0]                r_dn_data, w_dn_data_nxt;
    logic                      r_dn_valid, w_dn_valid_nxt;
    logic                      r_desync, w_desync_nxt;

    logic                      w_rx;
    logic                      w_send;
    logic [7:0]                w_res_byte;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic            w_to_fire;
`endif

    assign w_rx = bus.rxd_data_ready;

    // A byte may be launched only when the transmitter offers a slot and we
    // did not launch one on the previous cycle; the transmitter drops
    // tx_ready_next while busy, so each ready window yields one byte.
    assign w_send = bus.tx_ready_next && !r_tx_valid &&
                    ((r_state == ST_TX_STATUS) || (r_state == ST_TX_RESULT) ||
                     (r_state == ST_TX_ACK)    || (r_state == ST_TX_NAK)    ||
                     (r_state == ST_TX_ECHO));

    // Result byte selected by index, most significant byte first.
    always_comb begin
        w_res_byte = 8'h00;
        for (int i = 0; i < RESULT_BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_res_byte = r_result[8*(RESULT_BYTES-1-i) +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_arg_nxt      = r_arg;
        w_count_nxt    = r_count;
        w_idx_nxt      = r_idx;
        w_result_nxt   = r_result;
        w_status_nxt   = r_status;
        w_overrun_nxt  = r_overrun;
        w_ovr_resp_nxt = r_ovr_resp;
        w_timeout_nxt  = r_timeout;
        w_txd_data_nxt = r_txd_data;
        w_tx_valid_nxt = 1'b0;
        w_dn_data_nxt  = r_dn_data;
        w_dn_valid_nxt = 1'b0;
        w_desync_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rx) begin
                    case (bus.rxd_data)
                        OP_TEST:   w_state_nxt = ST_TEST_ARG;
                        OP_LOAD:   w_state_nxt = ST_LOAD_LEN;
                        OP_STATUS: begin
                            // Snapshot so core changes cannot alter bytes in flight.
                            w_state_nxt    = ST_TX_STATUS;
                            w_result_nxt   = bus.result_data;
                            w_status_nxt   = {4'b0000, r_timeout, r_overrun,
                                              bus.core_busy, bus.result_valid};
                            w_ovr_resp_nxt = 1'b0;
                        end
                        OP_DESYNC: begin
                            w_state_nxt  = ST_DESYNC;
                            w_desync_nxt = 1'b1;
                        end
                        default:   w_state_nxt = ST_TX_NAK;
                    endcase
                end
            end

            ST_TEST_ARG: begin
                if (w_rx) begin
                    w_arg_nxt   = bus.rxd_data;
                    w_state_nxt = ST_TX_ECHO;
                end
            end

            ST_LOAD_LEN: begin
                if (w_rx) begin
                    w_count_nxt = bus.rxd_data;
                    w_state_nxt = (bus.rxd_data == 8'h00) ? ST_TX_ACK : ST_LOAD_DATA;
                end
            end

            ST_LOAD_DATA: begin
                if (w_rx) begin
                    w_dn_data_nxt  = bus.rxd_data;
                    w_dn_valid_nxt = 1'b1;
                    w_count_nxt    = r_count - 8'd1;
                    if (r_count == 8'd1) begin
                        w_state_nxt = ST_TX_ACK;
                    end
                end
            end

            ST_TX_STATUS: begin
                if (w_rx) begin
                    w_overrun_nxt  = 1'b1;
                    w_ovr_resp_nxt = 1'b1;
                end
                if (w_send) begin
                    w_txd_data_nxt = r_status;
                    w_tx_valid_nxt = 1'b1;
                    w_idx_nxt      = '0;
                    w_state_nxt    = ST_TX_RESULT;
                end
            end

            ST_TX_RESULT: begin
                if (w_rx) begin
                    w_overrun_nxt  = 1'b1;
                    w_ovr_resp_nxt = 1'b1;
                end
                if (w_send) begin
                    w_txd_data_nxt = w_res_byte;
                    w_tx_valid_nxt = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        // Only the reported flags are cleared; an overrun
                        // that arrived during this response was not in the
                        // snapshot and stays pending for the next status.
                        w_overrun_nxt = w_ovr_resp_nxt;
                        w_timeout_nxt = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end

            ST_TX_ACK, ST_TX_NAK, ST_TX_ECHO: begin
                if (w_rx) begin
                    w_overrun_nxt = 1'b1;
                end
                if (w_send) begin
                    w_txd_data_nxt = (r_state == ST_TX_ACK) ? ACK_BYTE :
                                     (r_state == ST_TX_NAK) ? NAK_BYTE : r_arg;
                    w_tx_valid_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end

            ST_DESYNC: begin
                if (w_rx) begin
                    w_overrun_nxt = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end

            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Idle counter runs only while a command is partially received.
        w_to_cnt_nxt = '0;
        w_to_fire    = 1'b0;
        if (((r_state == ST_TEST_ARG) || (r_state == ST_LOAD_LEN) ||
             (r_state == ST_LOAD_DATA)) && !w_rx) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                w_to_fire = 1'b1;
            end else begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end
        end
        if (w_to_fire) begin
            w_state_nxt   = ST_IDLE;
            w_desync_nxt  = 1'b1;
            w_timeout_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_arg      <= 8'h00;
            r_count    <= 8'h00;
            r_idx      <= '0;
            r_result   <= '0;
            r_status   <= 8'h00;
            r_overrun  <= 1'b0;
            r_ovr_resp <= 1'b0;
            r_timeout  <= 1'b0;
            r_txd_data <= 8'h00;
            r_tx_valid <= 1'b0;
            r_dn_data  <= 8'h00;
            r_dn_valid <= 1'b0;
            r_desync   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_arg      <= w_arg_nxt;
            r_count    <= w_count_nxt;
            r_idx      <= w_idx_nxt;
            r_result   <= w_result_nxt;
            r_status   <= w_status_nxt;
            r_overrun  <= w_overrun_nxt;
            r_ovr_resp <= w_ovr_resp_nxt;
            r_timeout  <= w_timeout_nxt;
            r_txd_data <= w_txd_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_dn_data  <= w_dn_data_nxt;
            r_dn_valid <= w_dn_valid_nxt;
            r_desync   <= w_desync_nxt;
`ifdef CMD_TIMEOUT_EN
            r_to_cnt   <= w_to_cnt_nxt;
`endif
        end
    end

    assign bus.txd_data = r_txd_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.dn_data  = r_dn_data;
    assign bus.dn_valid = r_dn_valid;
    assign bus.desync   = r_desync;

endmodule

`default_nettype wire

// File: tb/tb_par8_cmd_controller.sv
// ============================================================================
// Module      : tb_par8_cmd_controller
// Description : Directed self-checking bench for par8_cmd_controller.
//               A negedge monitor collects transmitted bytes, core payload
//               bytes and desync pulses; directed steps compare them to
//               hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_par8_cmd_controller;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    par8_cmd_controller_if #(.RESULT_BYTES(4)) bus_if ();

    par8_cmd_controller #(
        .RESULT_BYTES(4),
        .ACK_BYTE    (8'h01),
        .NAK_BYTE    (8'hEE)
`ifdef CMD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_q[$];
    logic [7:0] dn_q[$];
    int         desync_pulses  = 0;
    int         desync_run     = 0;
    int         desync_max_run = 0;
    int         consec_tx      = 0;
    logic       prev_tx        = 1'b0;

    always @(negedge clk) begin
        if (bus_if.tx_valid) begin
            tx_q.push_back(bus_if.txd_data);
            if (prev_tx) consec_tx++;
        end
        prev_tx = bus_if.tx_valid;
        if (bus_if.dn_valid) dn_q.push_back(bus_if.dn_data);
        if (bus_if.desync) begin
            if (desync_run == 0) desync_pulses++;
            desync_run++;
            if (desync_run > desync_max_run) desync_max_run = desync_run;
        end else begin
            desync_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tx_at(input int i);
        return (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] dn_at(input int i);
        return (i < dn_q.size()) ? {24'h0, dn_q[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_mon();
        tx_q.delete();
        dn_q.delete();
        desync_pulses  = 0;
        desync_max_run = 0;
        consec_tx      = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus_if.rxd_data       = b;
        bus_if.rxd_data_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rxd_data_ready = 1'b0;
    endtask

    task automatic ready_pulses(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus_if.tx_ready_next = 1'b1;
            @(posedge clk); #1;
            bus_if.tx_ready_next = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.rxd_data       = 8'h00;
        bus_if.rxd_data_ready = 1'b0;
        bus_if.tx_ready_next  = 1'b0;
        bus_if.result_data    = 32'h0;
        bus_if.result_valid   = 1'b0;
        bus_if.core_busy      = 1'b0;

        // Reset state
        idle(3);
        chk("rst_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
        chk("rst_txd_data", {24'h0, bus_if.txd_data}, 32'h0);
        chk("rst_dn_valid", {31'h0, bus_if.dn_valid}, 32'h0);
        chk("rst_dn_data",  {24'h0, bus_if.dn_data},  32'h0);
        chk("rst_desync",   {31'h0, bus_if.desync},   32'h0);
        reset = 1'b1;
        idle(2);

        // LOAD 3 bytes
        clear_mon();
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'hAA);
        chk("load_dn_valid_lat", {31'h0, bus_if.dn_valid}, 32'h1);
        chk("load_dn_data_lat",  {24'h0, bus_if.dn_data},  32'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        idle(2);
        chk("load_dn_count", dn_q.size(), 32'd3);
        chk("load_dn0", dn_at(0), 32'hAA);
        chk("load_dn1", dn_at(1), 32'hBB);
        chk("load_dn2", dn_at(2), 32'hCC);
        chk("load_no_tx_before_ready", tx_q.size(), 32'd0);
        ready_pulses(2);
        chk("load_ack", tx_at(0), 32'h01);
        chk("load_single_ack", tx_q.size(), 32'd1);

        // NAK, echo, zero-length LOAD
        clear_mon();
        send_byte(8'h7F);
        ready_pulses(1);
        chk("nak", tx_at(0), 32'hEE);
        send_byte(8'h01);
        send_byte(8'h5A);
        ready_pulses(1);
        chk("echo", tx_at(1), 32'h5A);
        send_byte(8'h02);
        send_byte(8'h00);
        ready_pulses(1);
        chk("load0_ack", tx_at(2), 32'h01);
        chk("load0_no_dn", dn_q.size(), 32'd0);
        chk("tx_count_3", tx_q.size(), 32'd3);

        // STATUS with ready held high; core inputs change after the opcode
        clear_mon();
        bus_if.result_data  = 32'hDEADBEEF;
        bus_if.result_valid = 1'b1;
        bus_if.core_busy    = 1'b0;
        send_byte(8'h03);
        bus_if.result_data  = 32'h0;
        bus_if.result_valid = 1'b0;
        bus_if.core_busy    = 1'b1;
        bus_if.tx_ready_next = 1'b1;
        idle(14);
        bus_if.tx_ready_next = 1'b0;
        idle(2);
        chk("stat_count", tx_q.size(), 32'd5);
        chk("stat_byte", tx_at(0), 32'h01);
        chk("stat_res0", tx_at(1), 32'hDE);
        chk("stat_res1", tx_at(2), 32'hAD);
        chk("stat_res2", tx_at(3), 32'hBE);
        chk("stat_res3", tx_at(4), 32'hEF);
        chk("stat_no_consec_tx", consec_tx, 32'd0);

        // DESYNC
        clear_mon();
        send_byte(8'h05);
        ready_pulses(2);
        chk("desync_pulses", desync_pulses, 32'd1);
        chk("desync_width", desync_max_run, 32'd1);
        chk("desync_no_tx", tx_q.size(), 32'd0);

        // Reset mid LOAD
        clear_mon();
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'hAA);
        reset = 1'b0;
        idle(1);
        chk("midrst_dn_valid", {31'h0, bus_if.dn_valid}, 32'h0);
        chk("midrst_dn_data",  {24'h0, bus_if.dn_data},  32'h0);
        chk("midrst_tx_valid", {31'h0, bus_if.tx_valid}, 32'h0);
        chk("midrst_txd_data", {24'h0, bus_if.txd_data}, 32'h0);
        reset = 1'b1;
        bus_if.result_data  = 32'h01234567;
        bus_if.result_valid = 1'b0;
        bus_if.core_busy    = 1'b0;
        tx_q.delete();
        send_byte(8'h03);
        ready_pulses(5);
        chk("midrst_status", tx_at(0), 32'h00);
        chk("midrst_res0", tx_at(1), 32'h01);
        chk("midrst_res3", tx_at(4), 32'h67);

        // Overrun during TX_RESULT
        clear_mon();
        bus_if.result_data = 32'hCAFEF00D;
        bus_if.core_busy   = 1'b1;
        send_byte(8'h03);
        ready_pulses(2);
        send_byte(8'h99);
        ready_pulses(3);
        chk("ovr_dropped", dn_q.size(), 32'd0);
        chk("ovr_count", tx_q.size(), 32'd5);
        chk("ovr_status_first", tx_at(0), 32'h02);
        chk("ovr_res1", tx_at(2), 32'hFE);
        chk("ovr_res3", tx_at(4), 32'h0D);
        clear_mon();
        send_byte(8'h03);
        ready_pulses(5);
        chk("ovr_status_set", tx_at(0), 32'h06);
        clear_mon();
        send_byte(8'h03);
        ready_pulses(5);
        chk("ovr_status_clr", tx_at(0), 32'h02);

        // Silence in the middle of a LOAD
        clear_mon();
        bus_if.core_busy = 1'b0;
        send_byte(8'h02);
        send_byte(8'h05);
        send_byte(8'hAA);
`ifdef CMD_TIMEOUT_EN
        begin
            int hit;
            hit = -1;
            for (int k = 1; k <= 200; k++) begin
                @(posedge clk); #1;
                if (bus_if.desync && hit < 0) hit = k;
            end
            chk("to_cycle", hit, 32'd100);
        end
        chk("to_pulses", desync_pulses, 32'd1);
        chk("to_no_tx", tx_q.size(), 32'd0);
        send_byte(8'h03);
        ready_pulses(5);
        chk("to_status", tx_at(0), 32'h08);
`else
        idle(300);
        chk("wait_no_desync", desync_pulses, 32'd0);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        ready_pulses(1);
        chk("wait_ack", tx_at(0), 32'h01);
        chk("wait_dn_count", dn_q.size(), 32'd5);
        chk("wait_dn4", dn_at(4), 32'hEE);
        send_byte(8'h03);
        ready_pulses(5);
        chk("wait_status", tx_at(1), 32'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
